apb3_slave_mem: RTL and testbench

Synthesizable APB3 completer that responds to the PSEL/PENABLE/PWRITE/PADDR/PWDATA signal set and returns PRDATA/PREADY/PSLVERR. It is backed by a word-addressed register memory and has a runtime-programmable wait-state count. It is the DUT-side responder that the APB3 master agent drives in subsystem benches. It also serves as a reference slave model in loopback tests of the APB3 VIP.

---
 rtl/apb3_slave_mem.sv | 158 +++++++++++++++
 tb/tb_apb3_slave_mem.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb3_slave_mem.sv
// APB3 completer backed by a word-addressed register file with programmable wait states.
// Sticky prot_err flags master-side handshake violations until reset.
module apb3_slave_mem #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  input  logic [3:0]            wait_cfg,
  output logic                  prot_err,
  output logic                  o_dbg_state
);

  localparam int                    IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] SPAN  = ADDR_WIDTH'(DEPTH * 4);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_write;
  logic                  r_legal;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_prdata;
  logic                  r_pready;
  logic                  r_pslverr;
  logic                  r_prot_err;

  logic [ADDR_WIDTH-1:0] w_offset;
  logic                  w_legal;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_setup;
  logic                  w_bad_idle;
  logic                  w_access_ok;
  logic [DATA_WIDTH-1:0] w_setup_rdata;
  logic [DATA_WIDTH-1:0] w_cap_rdata;

  // Address decode on the live bus (used only at the setup edge).
  // Subtraction wraps, so addresses below BASE_ADDR land far above SPAN.
  always_comb begin
    w_offset = PADDR - BASE_ADDR;
    w_legal  = (w_offset < SPAN) && (PADDR[1:0] == 2'b00);
    w_idx    = w_offset[IDX_W+1:2];
  end

  // Handshake: a transfer starts when PSEL=1/PENABLE=0 is seen in IDLE, the
  // master must then hold PSEL=1/PENABLE=1 until it observes PREADY=1, and the
  // transfer completes at the edge on which PREADY=1 is presented.
  always_comb begin
    w_setup     = PSEL && !PENABLE;
    w_bad_idle  = PSEL && PENABLE;
    w_access_ok = PSEL && PENABLE;
  end

  always_comb begin
    w_setup_rdata = '0;
    w_cap_rdata   = '0;
    if (w_legal && !PWRITE) begin
      w_setup_rdata = r_mem[w_idx];
    end
    if (r_legal && !r_write) begin
      w_cap_rdata = r_mem[r_idx];
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_write    <= 1'b0;
      r_legal    <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_prdata   <= '0;
      r_pready   <= 1'b0;
      r_pslverr  <= 1'b0;
      r_prot_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_setup) begin
            r_write <= PWRITE;
            r_legal <= w_legal;
            r_idx   <= w_idx;
            r_wdata <= PWDATA;
            r_cnt   <= wait_cfg;
            r_state <= ST_ACCESS;
            if (wait_cfg == 4'd0) begin
              r_pready  <= 1'b1;
              r_pslverr <= !w_legal;
              r_prdata  <= w_setup_rdata;
            end
          end else if (w_bad_idle) begin
            r_prot_err <= 1'b1;
          end
        end

        ST_ACCESS: begin
          if (r_pready) begin
            if (r_write && r_legal) begin
              r_mem[r_idx] <= r_wdata;
            end
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
            r_state   <= ST_IDLE;
          end else if (!w_access_ok) begin
            // Master walked away mid-transfer: drop it without touching memory.
            r_prot_err <= 1'b1;
            r_pready   <= 1'b0;
            r_pslverr  <= 1'b0;
            r_prdata   <= '0;
            r_cnt      <= '0;
            r_state    <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
              r_pready  <= 1'b1;
              r_pslverr <= !r_legal;
              r_prdata  <= w_cap_rdata;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    PRDATA      = r_prdata;
    PREADY      = r_pready;
    PSLVERR     = r_pslverr;
    prot_err    = r_prot_err;
    o_dbg_state = r_state;
  end

endmodule

// File: tb/tb_apb3_slave_mem.sv
// Directed bench for apb3_slave_mem: latency, read/write data, decode errors,
// back-to-back transfers, aborted transfers and mid-transfer reset.
module tb_apb3_slave_mem;

  logic        PCLK;
  logic        PRESET;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [3:0]  wait_cfg;
  logic        prot_err;
  logic        dbg_state;

  int n_checks;
  int n_err;

  logic [31:0] rd;
  logic        err;
  int          lat;

  apb3_slave_mem #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .DEPTH     (16),
    .BASE_ADDR (32'h0000_0000)
  ) dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR),
    .wait_cfg   (wait_cfg),
    .prot_err   (prot_err),
    .o_dbg_state(dbg_state)
  );

  // Clock / reset
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    repeat (cycles) @(posedge PCLK);
    #1;
    PRESET = 1'b0;
  endtask

  // Runs setup + access phases and returns once PREADY=1 is observed
  // (still inside the completion cycle). Address/data/wait_cfg are scrambled
  // after setup, since only the setup values may matter.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] waits, output logic [31:0] rdata,
                          output logic slverr, output int nlat);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata; wait_cfg = waits;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; PWRITE = ~wr; PADDR = addr ^ 32'h0000_00FC; PWDATA = ~wdata; wait_cfg = ~waits;
    nlat = 1;
    while (PREADY !== 1'b1 && nlat < 40) begin
      @(posedge PCLK); #1;
      nlat++;
    end
    rdata  = PRDATA;
    slverr = PSLVERR;
  endtask

  task automatic go_idle(input string tag);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    check(tag, {31'd0, PREADY}, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; wait_cfg = '0;

    // Reset values
    do_reset(2);
    check("rst_pready",   {31'd0, PREADY},   32'd0);
    check("rst_pslverr",  {31'd0, PSLVERR},  32'd0);
    check("rst_prdata",   PRDATA,            32'd0);
    check("rst_prot_err", {31'd0, prot_err}, 32'd0);

    // Read 0x0C, no wait states
    apb_xfer(1'b0, 32'h0C, 32'h0, 4'd0, rd, err, lat);
    check("rd0c_lat",  lat,            32'd1);
    check("rd0c_data", rd,             32'd0);
    check("rd0c_err",  {31'd0, err},   32'd0);
    go_idle("rd0c_ready_drop");

    // Write then read 0x08 with 3 wait states
    apb_xfer(1'b1, 32'h08, 32'h1234_5678, 4'd3, rd, err, lat);
    check("wr08_lat", lat,          32'd4);
    check("wr08_err", {31'd0, err}, 32'd0);
    go_idle("wr08_ready_drop");
    apb_xfer(1'b0, 32'h08, 32'h0, 4'd3, rd, err, lat);
    check("rd08_lat",  lat,          32'd4);
    check("rd08_data", rd,           32'h1234_5678);
    check("rd08_err",  {31'd0, err}, 32'd0);
    go_idle("rd08_ready_drop");

    // Out-of-range and misaligned writes
    apb_xfer(1'b1, 32'h40, 32'hDEAD_BEEF, 4'd1, rd, err, lat);
    check("wr40_lat", lat,          32'd2);
    check("wr40_err", {31'd0, err}, 32'd1);
    go_idle("wr40_ready_drop");
    apb_xfer(1'b1, 32'h06, 32'hDEAD_BEEF, 4'd0, rd, err, lat);
    check("wr06_err", {31'd0, err}, 32'd1);
    go_idle("wr06_ready_drop");
    apb_xfer(1'b0, 32'h04, 32'h0, 4'd0, rd, err, lat);
    check("rd04_data", rd,          32'd0);
    check("rd04_err",  {31'd0, err}, 32'd0);
    go_idle("rd04_ready_drop");
    apb_xfer(1'b0, 32'h00, 32'h0, 4'd2, rd, err, lat);
    check("rd00_after_bad", rd, 32'd0);
    go_idle("rd00_ready_drop");
    apb_xfer(1'b0, 32'h42, 32'h0, 4'd0, rd, err, lat);
    check("rd42_data", rd,          32'd0);
    check("rd42_err",  {31'd0, err}, 32'd1);
    go_idle("rd42_ready_drop");

    // Back-to-back writes, no idle cycle in between
    apb_xfer(1'b1, 32'h00, 32'h1111_0000, 4'd0, rd, err, lat);
    check("b2b0_lat", lat, 32'd1);
    apb_xfer(1'b1, 32'h04, 32'h2222_0004, 4'd0, rd, err, lat);
    check("b2b1_lat", lat, 32'd1);
    apb_xfer(1'b0, 32'h00, 32'h0, 4'd0, rd, err, lat);
    check("b2b_rd00", rd,  32'h1111_0000);
    check("b2b2_lat", lat, 32'd1);
    apb_xfer(1'b0, 32'h04, 32'h0, 4'd0, rd, err, lat);
    check("b2b_rd04", rd, 32'h2222_0004);
    go_idle("b2b_ready_drop");
    check("b2b_prot_err", {31'd0, prot_err}, 32'd0);

    // Aborted write: PSEL dropped in the 2nd access cycle
    apb_xfer(1'b1, 32'h10, 32'h5555_AAAA, 4'd2, rd, err, lat);
    go_idle("pre_abort_ready_drop");
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h10; PWDATA = 32'h7777_7777; wait_cfg = 4'd5;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    check("abort_acc1_ready", {31'd0, PREADY}, 32'd0);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    check("abort_acc2_ready", {31'd0, PREADY}, 32'd0);
    @(posedge PCLK); #1;
    check("abort_prot_err", {31'd0, prot_err}, 32'd1);
    check("abort_ready",    {31'd0, PREADY},   32'd0);
    check("abort_state",    {31'd0, dbg_state}, 32'd0);
    repeat (5) @(posedge PCLK);
    #1;
    check("abort_ready_later", {31'd0, PREADY}, 32'd0);
    apb_xfer(1'b0, 32'h10, 32'h0, 4'd0, rd, err, lat);
    check("abort_rd10", rd, 32'h5555_AAAA);
    go_idle("abort_rd_ready_drop");
    check("abort_prot_err_sticky", {31'd0, prot_err}, 32'd1);

    // Reset pulsed during wait states of a write
    do_reset(1);
    check("rst2_prot_err", {31'd0, prot_err}, 32'd0);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h00; PWDATA = 32'hA5A5_A5A5; wait_cfg = 4'd4;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    check("midrst_ready",    {31'd0, PREADY},   32'd0);
    check("midrst_prot_err", {31'd0, prot_err}, 32'd0);
    check("midrst_prdata",   PRDATA,            32'd0);
    repeat (6) @(posedge PCLK);
    #1;
    check("midrst_ready_later", {31'd0, PREADY}, 32'd0);
    apb_xfer(1'b0, 32'h00, 32'h0, 4'd1, rd, err, lat);
    check("midrst_rd00", rd, 32'd0);
    go_idle("midrst_rd00_drop");
    apb_xfer(1'b0, 32'h08, 32'h0, 4'd0, rd, err, lat);
    check("midrst_rd08", rd, 32'd0);
    go_idle("midrst_rd08_drop");
    check("midrst_prot_err_end", {31'd0, prot_err}, 32'd0);

    // PSEL+PENABLE seen in IDLE without a setup phase
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'h0C; PWDATA = 32'hFFFF_FFFF;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    check("idle_viol_prot_err", {31'd0, prot_err},  32'd1);
    check("idle_viol_ready",    {31'd0, PREADY},    32'd0);
    check("idle_viol_state",    {31'd0, dbg_state}, 32'd0);
    apb_xfer(1'b0, 32'h0C, 32'h0, 4'd0, rd, err, lat);
    check("idle_viol_rd0c", rd, 32'd0);
    go_idle("idle_viol_drop");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
